// File: rtl/axi_rd_arbiter_if.sv
// Bundled AR/R signals of the read arbiter: two upstream read masters (icache, LSU)
// and the merged AXI4 read master toward the SoC bus.
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              icache_arvalid;
  logic              icache_arready;
  logic [ADDR_W-1:0] icache_araddr;
  logic [1:0]        icache_arburst;
  logic [7:0]        icache_arlen;
  logic [2:0]        icache_arsize;
  logic              icache_rvalid;
  logic              icache_rready;
  logic [DATA_W-1:0] icache_rdata;
  logic [1:0]        icache_rresp;
  logic              icache_rlast;

  logic              exu_arvalid;
  logic              exu_arready;
  logic [ADDR_W-1:0] exu_araddr;
  logic [2:0]        exu_arsize;
  logic              lsu_rvalid;
  logic              lsu_rready;
  logic [DATA_W-1:0] lsu_rdata;
  logic [1:0]        lsu_rresp;

  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_rvalid;
  logic              m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;

  logic              beat_err;

  // Arbiter side.
  modport slave (
    input  icache_arvalid, icache_araddr, icache_arburst, icache_arlen, icache_arsize,
    input  icache_rready,
    output icache_arready, icache_rvalid, icache_rdata, icache_rresp, icache_rlast,
    input  exu_arvalid, exu_araddr, exu_arsize, lsu_rready,
    output exu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
    output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output beat_err
  );

  // Environment side: upstream requesters plus the downstream slave.
  modport master (
    output icache_arvalid, icache_araddr, icache_arburst, icache_arlen, icache_arsize,
    output icache_rready,
    input  icache_arready, icache_rvalid, icache_rdata, icache_rresp, icache_rlast,
    output exu_arvalid, exu_araddr, exu_arsize, lsu_rready,
    input  exu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
    input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input  beat_err
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Merges the icache burst port and LSU single-beat port onto one AXI4 read master,
// one outstanding transaction at a time, LSU first when both request together.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic            clock,
  input logic            reset,
  axi_rd_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, IF_AR, IF_R, LS_AR, LS_R} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic [8:0]        beat_cnt;
  logic              beat_err_q;
  logic              hold_off;
  logic              grant_ls, grant_if;
  logic              r_hs;

  logic exu_arready, icache_arready, m_arvalid, m_rready;
  logic icache_rvalid, lsu_rvalid, icache_rlast;

  // NOTE: every output gets a default first so no latch is inferred for unlisted cases.
  always_comb begin
    state_nxt      = state;
    grant_ls       = 1'b0;
    grant_if       = 1'b0;
    exu_arready    = 1'b0;
    icache_arready = 1'b0;
    m_arvalid      = 1'b0;
    m_rready       = 1'b0;
    icache_rvalid  = 1'b0;
    lsu_rvalid     = 1'b0;
    icache_rlast   = 1'b0;
    unique case (state)
      IDLE: begin
        // hold_off marks the first cycle back in IDLE; no grant is given there.
        if (!hold_off) begin
          if (bus.exu_arvalid) begin
            grant_ls    = 1'b1;
            exu_arready = 1'b1;
            state_nxt   = LS_AR;
          end else if (bus.icache_arvalid) begin
            grant_if       = 1'b1;
            icache_arready = 1'b1;
            state_nxt      = IF_AR;
          end
        end
      end
      IF_AR, LS_AR: begin
        m_arvalid = 1'b1;
        if (bus.m_arready) state_nxt = (state == IF_AR) ? IF_R : LS_R;
      end
      IF_R: begin
        icache_rvalid = bus.m_rvalid;
        m_rready      = bus.icache_rready;
        icache_rlast  = bus.m_rlast;
        if (bus.m_rvalid && bus.icache_rready && bus.m_rlast) state_nxt = IDLE;
      end
      LS_R: begin
        lsu_rvalid = bus.m_rvalid;
        m_rready   = bus.lsu_rready;
        if (bus.m_rvalid && bus.lsu_rready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign r_hs = bus.m_rvalid && m_rready;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ar_addr    <= '0;
      ar_len     <= '0;
      ar_size    <= '0;
      ar_burst   <= '0;
      beat_cnt   <= '0;
      beat_err_q <= 1'b0;
      hold_off   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_off <= (state != IDLE) && (state_nxt == IDLE);
      if (grant_ls) begin
        ar_addr  <= bus.exu_araddr;
        ar_size  <= bus.exu_arsize;
        ar_len   <= 8'd0;
        ar_burst <= 2'b01;
      end else if (grant_if) begin
        ar_addr  <= bus.icache_araddr;
        ar_size  <= bus.icache_arsize;
        ar_len   <= bus.icache_arlen;
        ar_burst <= bus.icache_arburst;
        beat_cnt <= '0;
      end
      if (state == IF_R && r_hs) begin
        // Saturate so an endless burst cannot wrap back onto a matching count.
        if (beat_cnt != '1) beat_cnt <= beat_cnt + 9'd1;
        if (bus.m_rlast && beat_cnt != {1'b0, ar_len}) beat_err_q <= 1'b1;
      end
      if (state == LS_R && r_hs && !bus.m_rlast) beat_err_q <= 1'b1;
    end
  end

  assign bus.exu_arready    = exu_arready;
  assign bus.icache_arready = icache_arready;
  assign bus.m_arvalid      = m_arvalid;
  assign bus.m_araddr       = ar_addr;
  assign bus.m_arlen        = ar_len;
  assign bus.m_arsize       = ar_size;
  assign bus.m_arburst      = ar_burst;
  assign bus.m_rready       = m_rready;
  assign bus.icache_rvalid  = icache_rvalid;
  assign bus.icache_rlast   = icache_rlast;
  assign bus.icache_rdata   = bus.m_rdata;
  assign bus.icache_rresp   = bus.m_rresp;
  assign bus.lsu_rvalid     = lsu_rvalid;
  assign bus.lsu_rdata      = bus.m_rdata;
  assign bus.lsu_rresp      = bus.m_rresp;
  assign bus.beat_err       = beat_err_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Cycle-by-cycle vector table for the read arbiter plus a hand-written long-burst sequence.
module tb_axi_rd_arbiter;
  localparam logic [31:0] LA = 32'h8000_0004;
  localparam logic [31:0] IA = 32'h3000_0000;
  localparam int NROWS = 36;

  typedef struct {
    logic rst, ev, iv, ar, rv, rl, irr, lrr;
    logic [31:0] rd;
    logic xar, iar, mav;
    logic [31:0] maddr;
    logic [7:0]  mlen;
    logic [1:0]  mburst;
    logic lrv, irv, ilast, mrr, err;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t tbl [NROWS];

  axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, ev, iv, ar, rv, rl, irr, lrr, input logic [31:0] rd);
    reset              = rst;
    bus.exu_arvalid    = ev;
    bus.icache_arvalid = iv;
    bus.m_arready      = ar;
    bus.m_rvalid       = rv;
    bus.m_rlast        = rl;
    bus.icache_rready  = irr;
    bus.lsu_rready     = lrr;
    bus.m_rdata        = rd;
  endtask

  task automatic check_row(input int i, input vec_t v);
    string p;
    p = $sformatf("row%0d", i);
    check({p, " exu_arready"},    32'(bus.exu_arready),    32'(v.xar));
    check({p, " icache_arready"}, 32'(bus.icache_arready), 32'(v.iar));
    check({p, " m_arvalid"},      32'(bus.m_arvalid),      32'(v.mav));
    check({p, " m_araddr"},       bus.m_araddr,            v.maddr);
    check({p, " m_arlen"},        32'(bus.m_arlen),        32'(v.mlen));
    check({p, " m_arburst"},      32'(bus.m_arburst),      32'(v.mburst));
    check({p, " lsu_rvalid"},     32'(bus.lsu_rvalid),     32'(v.lrv));
    check({p, " icache_rvalid"},  32'(bus.icache_rvalid),  32'(v.irv));
    check({p, " icache_rlast"},   32'(bus.icache_rlast),   32'(v.ilast));
    check({p, " m_rready"},       32'(bus.m_rready),       32'(v.mrr));
    check({p, " beat_err"},       32'(bus.beat_err),       32'(v.err));
    if (v.mav)
      check({p, " m_arsize"}, 32'(bus.m_arsize), (v.maddr == IA) ? 32'd3 : 32'd2);
    if (v.lrv) begin
      check({p, " lsu_rdata"}, bus.lsu_rdata, v.rd);
      check({p, " lsu_rresp"}, 32'(bus.lsu_rresp), 32'd2);
    end
    if (v.irv) begin
      check({p, " icache_rdata"}, bus.icache_rdata, v.rd);
      check({p, " icache_rresp"}, 32'(bus.icache_rresp), 32'd2);
    end
  endtask

  initial begin
    // rst ev iv ar rv rl irr lrr rd | xar iar mav maddr mlen mburst lrv irv ilast mrr err
    // LSU load alone
    tbl[0]  = '{0,0,0,0,0,0,0,0,32'h0,         0,0,0,32'h0,0,0, 0,0,0,0,0};
    tbl[1]  = '{0,1,0,0,0,0,0,0,32'h0,         1,0,0,32'h0,0,0, 0,0,0,0,0};
    tbl[2]  = '{0,0,0,1,0,0,0,0,32'h0,         0,0,1,LA,0,1,    0,0,0,0,0};
    tbl[3]  = '{0,0,0,0,0,0,0,1,32'h0,         0,0,0,LA,0,1,    0,0,0,1,0};
    tbl[4]  = '{0,0,0,0,1,1,0,1,32'hDEADBEEF,  0,0,0,LA,0,1,    1,0,0,1,0};
    // simultaneous requests, LSU wins, icache waits out the idle cycle
    tbl[5]  = '{0,0,1,0,0,0,0,0,32'h0,         0,0,0,LA,0,1,    0,0,0,0,0};
    tbl[6]  = '{0,1,1,0,0,0,0,0,32'h0,         1,0,0,LA,0,1,    0,0,0,0,0};
    tbl[7]  = '{0,0,1,1,0,0,0,0,32'h0,         0,0,1,LA,0,1,    0,0,0,0,0};
    tbl[8]  = '{0,0,1,0,1,1,0,1,32'h11111111,  0,0,0,LA,0,1,    1,0,0,1,0};
    tbl[9]  = '{0,0,1,0,0,0,0,0,32'h0,         0,0,0,LA,0,1,    0,0,0,0,0};
    tbl[10] = '{0,0,1,0,0,0,0,0,32'h0,         0,1,0,LA,0,1,    0,0,0,0,0};
    // icache burst of 4 with 3 cycles of backpressure on beat 2
    tbl[11] = '{0,0,0,0,0,0,0,0,32'h0,         0,0,1,IA,3,1,    0,0,0,0,0};
    tbl[12] = '{0,0,0,1,0,0,0,0,32'h0,         0,0,1,IA,3,1,    0,0,0,0,0};
    tbl[13] = '{0,0,0,0,1,0,1,0,32'hB0B0B0B0,  0,0,0,IA,3,1,    0,1,0,1,0};
    tbl[14] = '{0,0,0,0,1,0,0,0,32'hB1B1B1B1,  0,0,0,IA,3,1,    0,1,0,0,0};
    tbl[15] = '{0,0,0,0,1,0,0,0,32'hB1B1B1B1,  0,0,0,IA,3,1,    0,1,0,0,0};
    tbl[16] = '{0,0,0,0,1,0,0,0,32'hB1B1B1B1,  0,0,0,IA,3,1,    0,1,0,0,0};
    tbl[17] = '{0,0,0,0,1,0,1,0,32'hB1B1B1B1,  0,0,0,IA,3,1,    0,1,0,1,0};
    tbl[18] = '{0,0,0,0,0,0,1,0,32'h0,         0,0,0,IA,3,1,    0,0,0,1,0};
    tbl[19] = '{0,0,0,0,1,0,1,0,32'hB2B2B2B2,  0,0,0,IA,3,1,    0,1,0,1,0};
    tbl[20] = '{0,0,0,0,1,1,1,0,32'hB3B3B3B3,  0,0,0,IA,3,1,    0,1,1,1,0};
    tbl[21] = '{0,0,0,0,0,0,0,0,32'h0,         0,0,0,IA,3,1,    0,0,0,0,0};
    // early rlast on beat 2 of a 4-beat burst
    tbl[22] = '{0,0,1,0,0,0,0,0,32'h0,         0,1,0,IA,3,1,    0,0,0,0,0};
    tbl[23] = '{0,0,0,1,0,0,0,0,32'h0,         0,0,1,IA,3,1,    0,0,0,0,0};
    tbl[24] = '{0,0,0,0,1,0,1,0,32'hC0C0C0C0,  0,0,0,IA,3,1,    0,1,0,1,0};
    tbl[25] = '{0,0,0,0,1,1,1,0,32'hC1C1C1C1,  0,0,0,IA,3,1,    0,1,1,1,0};
    tbl[26] = '{0,0,0,0,0,0,0,0,32'h0,         0,0,0,IA,3,1,    0,0,0,0,1};
    // reset in IF_R after beat 1; stale beats are not routed
    tbl[27] = '{0,0,1,0,0,0,0,0,32'h0,         0,1,0,IA,3,1,    0,0,0,0,1};
    tbl[28] = '{0,0,0,1,0,0,0,0,32'h0,         0,0,1,IA,3,1,    0,0,0,0,1};
    tbl[29] = '{0,0,0,0,1,0,1,0,32'hE0E0E0E0,  0,0,0,IA,3,1,    0,1,0,1,1};
    tbl[30] = '{1,0,0,0,1,0,1,0,32'hE1E1E1E1,  0,0,0,IA,3,1,    0,1,0,1,1};
    tbl[31] = '{0,0,0,0,1,0,1,1,32'hE2E2E2E2,  0,0,0,32'h0,0,0, 0,0,0,0,0};
    tbl[32] = '{0,1,0,0,1,0,1,1,32'hE3E3E3E3,  1,0,0,32'h0,0,0, 0,0,0,0,0};
    // LSU beat without rlast flags beat_err
    tbl[33] = '{0,0,0,1,0,0,0,0,32'h0,         0,0,1,LA,0,1,    0,0,0,0,0};
    tbl[34] = '{0,0,0,0,1,0,0,1,32'hF0F0F0F0,  0,0,0,LA,0,1,    1,0,0,1,0};
    tbl[35] = '{0,0,0,0,0,0,0,0,32'h0,         0,0,0,LA,0,1,    0,0,0,0,1};

    bus.exu_araddr     = LA;
    bus.exu_arsize     = 3'd2;
    bus.icache_araddr  = IA;
    bus.icache_arlen   = 8'd3;
    bus.icache_arburst = 2'b01;
    bus.icache_arsize  = 3'd3;
    bus.m_rresp        = 2'b10;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clock);

    for (int i = 0; i < NROWS; i++) begin
      @(posedge clock);
      #1;
      drive(tbl[i].rst, tbl[i].ev, tbl[i].iv, tbl[i].ar, tbl[i].rv, tbl[i].rl,
            tbl[i].irr, tbl[i].lrr, tbl[i].rd);
      @(negedge clock);
      check_row(i, tbl[i]);
    end

    // Long burst: arlen=3 but six beats before rlast; all forwarded, beat_err set.
    @(posedge clock); #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(posedge clock); #1;
    drive(0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clock);
    check("long icache_arready", 32'(bus.icache_arready), 32'd1);
    check("long beat_err_clear", 32'(bus.beat_err), 32'd0);
    @(posedge clock); #1;
    drive(0, 0, 0, 1, 0, 0, 0, 0, 32'h0);
    @(negedge clock);
    check("long m_arvalid", 32'(bus.m_arvalid), 32'd1);
    for (int b = 0; b < 6; b++) begin
      @(posedge clock); #1;
      drive(0, 0, 0, 0, 1, (b == 5), 1, 0, 32'hA000_0000 + 32'(b));
      @(negedge clock);
      check($sformatf("long beat%0d rvalid", b), 32'(bus.icache_rvalid), 32'd1);
      check($sformatf("long beat%0d rdata", b), bus.icache_rdata, 32'hA000_0000 + 32'(b));
      check($sformatf("long beat%0d rlast", b), 32'(bus.icache_rlast), (b == 5) ? 32'd1 : 32'd0);
      check($sformatf("long beat%0d m_rready", b), 32'(bus.m_rready), 32'd1);
    end
    @(posedge clock); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    @(negedge clock);
    check("long beat_err", 32'(bus.beat_err), 32'd1);
    check("long icache_rvalid_idle", 32'(bus.icache_rvalid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
